// File: rtl/mux_8.sv
// Registered 8-to-1 datapath multiplexer. Select codes at or above 8 are invalid:
// they load zero and raise sel_invalid. Both outputs update one cycle after select.
module mux_8 #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic [WIDTH-1:0]     in3,
  input  logic [WIDTH-1:0]     in4,
  input  logic [WIDTH-1:0]     in5,
  input  logic [WIDTH-1:0]     in6,
  input  logic [WIDTH-1:0]     in7,
  input  logic [SEL_WIDTH-1:0] select,
  output logic [WIDTH-1:0]     out,
  output logic                 sel_invalid
);

  logic [WIDTH-1:0] data_p0;
  logic             invalid_p0;

  // Stage 0: full-width decode. Codes >= 8 fall to default and never alias onto inputs.
  always_comb begin
    data_p0    = '0;
    invalid_p0 = 1'b1;
    case (select)
      SEL_WIDTH'(0): begin data_p0 = in0; invalid_p0 = 1'b0; end
      SEL_WIDTH'(1): begin data_p0 = in1; invalid_p0 = 1'b0; end
      SEL_WIDTH'(2): begin data_p0 = in2; invalid_p0 = 1'b0; end
      SEL_WIDTH'(3): begin data_p0 = in3; invalid_p0 = 1'b0; end
      SEL_WIDTH'(4): begin data_p0 = in4; invalid_p0 = 1'b0; end
      SEL_WIDTH'(5): begin data_p0 = in5; invalid_p0 = 1'b0; end
      SEL_WIDTH'(6): begin data_p0 = in6; invalid_p0 = 1'b0; end
      SEL_WIDTH'(7): begin data_p0 = in7; invalid_p0 = 1'b0; end
      default: ;
    endcase
  end

  // Stage 1: output registers, reloaded every edge with no enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= '0;
      sel_invalid <= 1'b0;
    end else begin
      out         <= data_p0;
      sel_invalid <= invalid_p0;
    end
  end

endmodule

// File: tb/tb_mux_8.sv
// Bench for mux_8: directed scenarios plus randomized traffic against an array-based reference.
module tb_mux_8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din [8];
  logic [3:0] select = 4'd0;
  logic [7:0] out;
  logic       sel_invalid;

  int checks = 0;
  int failures = 0;

  mux_8 #(.WIDTH(8), .SEL_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .select(select), .out(out), .sel_invalid(sel_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: source k for k < 8, zero with flag otherwise.
  function automatic logic [7:0] ref_out(input int sel);
    return (sel < 8) ? din[sel] : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ladder();
    for (int k = 0; k < 8; k++) din[k] = 8'(k * 8'h11);
  endtask

  initial begin
    logic [7:0] exp_out;
    logic       exp_inv;

    for (int k = 0; k < 8; k++) din[k] = 8'h00;

    // Reset with no clock edge
    set_ladder();
    select = 4'd3;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check("reset_out", 32'(out), 32'h00);
    check("reset_inv", 32'(sel_invalid), 32'h0);
    // Edge with reset held high keeps outputs cleared
    step();
    check("reset_edge_out", 32'(out), 32'h00);
    #2 reset = 1'b0;
    #1;
    check("reset_release_out", 32'(out), 32'h00);

    // Ascending sweep
    for (int s = 0; s < 8; s++) begin
      select = 4'(s);
      step();
      check($sformatf("asc_out%0d", s), 32'(out), 32'(s * 8'h11));
      check($sformatf("asc_inv%0d", s), 32'(sel_invalid), 32'h0);
    end

    // Descending sweep
    for (int s = 7; s >= 0; s--) begin
      select = 4'(s);
      step();
      check($sformatf("desc_out%0d", s), 32'(out), 32'(s * 8'h11));
    end

    // Latency: mid-cycle change is invisible until the next edge
    select = 4'd1;
    step();
    check("lat_before", 32'(out), 32'h11);
    #2 select = 4'd2;
    #1;
    check("lat_mid", 32'(out), 32'h11);
    step();
    check("lat_after", 32'(out), 32'h22);

    // Invalid codes, including one that would alias onto in4 if truncated
    foreach (din[k]) din[k] = din[k];
    for (int i = 0; i < 3; i++) begin
      int code;
      code = (i == 0) ? 8 : (i == 1) ? 12 : 15;
      select = 4'(code);
      step();
      check($sformatf("inv_out%0d", code), 32'(out), 32'h00);
      check($sformatf("inv_flag%0d", code), 32'(sel_invalid), 32'h1);
    end
    select = 4'd4;
    step();
    check("recover_out", 32'(out), 32'h44);
    check("recover_inv", 32'(sel_invalid), 32'h0);

    // Reset mid-stream
    select = 4'd5;
    step();
    check("mid_pre", 32'(out), 32'h55);
    #2 reset = 1'b1;
    #1;
    check("mid_reset", 32'(out), 32'h00);
    #1 reset = 1'b0;
    #1;
    check("mid_hold", 32'(out), 32'h00);
    step();
    check("mid_return", 32'(out), 32'h55);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      int sel;
      for (int k = 0; k < 8; k++) din[k] = 8'($urandom);
      sel = int'($urandom_range(0, 15));
      select = 4'(sel);
      exp_out = ref_out(sel);
      exp_inv = (sel >= 8);
      step();
      check("rand_out", 32'(out), 32'(exp_out));
      check("rand_inv", 32'(sel_invalid), 32'(exp_inv));
      // Glitch on select between edges must not leak
      #2 select = 4'($urandom);
      #1;
      check("rand_hold_out", 32'(out), 32'(exp_out));
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        #1;
        check("rand_rst_out", 32'(out), 32'h00);
        check("rand_rst_inv", 32'(sel_invalid), 32'h0);
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
